arcade_round_controller: RTL and testbench

//  Sequences one Binary Arcade game: draws a pseudo-random target, presents it to the player,

---
 rtl/arcade_pkg.sv | 28 ++
 rtl/arcade_lfsr.sv | 32 +++
 rtl/arcade_round_controller.sv | 151 +++++++++++++++
 tb/tb_arcade_round_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/arcade_pkg.sv
// Shared types and constants for the Binary Arcade round controller.
// State encoding, score width and per-width LFSR feedback tap masks.
package arcade_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam int unsigned SCORE_W = 4;

    // Fibonacci tap masks (bit i set = state bit i feeds the XOR), maximal-length per width
    function automatic logic [7:0] lfsr_taps(input int unsigned width);
        logic [7:0] mask;
        case (width)
            4:       mask = 8'b0000_1100;
            5:       mask = 8'b0001_0100;
            6:       mask = 8'b0011_0000;
            7:       mask = 8'b0110_0000;
            8:       mask = 8'b1011_1000;
            default: mask = 8'b0000_1100;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/arcade_lfsr.sv
// Left-shifting Fibonacci LFSR producing the round targets; advances only when step=1.
module arcade_lfsr
    import arcade_pkg::*;
#(
    parameter int unsigned       WIDTH     = 4,
    parameter logic [WIDTH-1:0]  LFSR_SEED = 4'b1001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(lfsr_taps(WIDTH));

    logic             feedback;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        feedback = ^(value & TAP_MASK);
        value_d  = {value[WIDTH-2:0], feedback};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else if (step) begin
            value <= value_d;
        end
    end

endmodule

// File: rtl/arcade_round_controller.sv
// Binary Arcade round sequencer: target draw, guess judging, round timeout, score.
// Optional lives counter enabled by defining ARCADE_LIVES_EN.
module arcade_round_controller
    import arcade_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned TARGET_SCORE = 10,
    parameter int unsigned ROUND_CYCLES = 16,
    parameter logic [7:0]  LFSR_SEED    = 8'h09
`ifdef ARCADE_LIVES_EN
    ,
    parameter int unsigned MAX_LIVES    = 3
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   guess,
    input  logic               guess_valid,
    output logic [WIDTH-1:0]   target,
    output logic               target_valid,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
`ifdef ARCADE_LIVES_EN
    ,
    output logic [1:0]         lives_left
`endif
);

    localparam int unsigned          TIMER_W    = $clog2(ROUND_CYCLES);
    localparam logic [TIMER_W-1:0]   TIMER_LOAD = TIMER_W'(ROUND_CYCLES - 1);
    localparam logic [SCORE_W-1:0]   TARGET     = SCORE_W'(TARGET_SCORE);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [WIDTH-1:0]     target_d;
    logic [SCORE_W-1:0]   score_d;
    logic                 hit_d, miss_d, target_valid_d, game_over_d;
    logic                 lfsr_step;
    logic [WIDTH-1:0]     lfsr_value;
`ifdef ARCADE_LIVES_EN
    localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);
    logic [1:0]           lives_d;
`endif

    arcade_lfsr #(
        .WIDTH     (WIDTH),
        .LFSR_SEED (LFSR_SEED[WIDTH-1:0])
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        target_d  = target;
        score_d   = score;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        lfsr_step = 1'b0;
`ifdef ARCADE_LIVES_EN
        lives_d   = lives_left;
`endif

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StArm;
                    score_d = '0;
`ifdef ARCADE_LIVES_EN
                    lives_d = LIVES_INIT;
`endif
                end
            end
            StArm: begin
                target_d  = lfsr_value;
                lfsr_step = 1'b1;
                timer_d   = TIMER_LOAD;
                state_d   = StWait;
            end
            StWait: begin
                // A guess on the last timer cycle wins over the timeout
                if (guess_valid) begin
                    if (guess == target) begin
                        hit_d = 1'b1;
                        if (score < TARGET) begin
                            score_d = score + 1'b1;
                        end
                        state_d = (score_d == TARGET) ? StDone : StArm;
                    end else begin
                        miss_d = 1'b1;
                    end
                end else if (timer_q == '0) begin
                    miss_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end

                if (miss_d) begin
                    state_d = StArm;
`ifdef ARCADE_LIVES_EN
                    if (lives_left != 2'd0) begin
                        lives_d = lives_left - 2'd1;
                    end
                    if (lives_left <= 2'd1) begin
                        state_d = StDone;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        target_valid_d = (state_d == StWait);
        game_over_d    = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            target       <= '0;
            target_valid <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            score        <= '0;
            game_over    <= 1'b0;
`ifdef ARCADE_LIVES_EN
            lives_left   <= LIVES_INIT;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            target       <= target_d;
            target_valid <= target_valid_d;
            hit          <= hit_d;
            miss         <= miss_d;
            score        <= score_d;
            game_over    <= game_over_d;
`ifdef ARCADE_LIVES_EN
            lives_left   <= lives_d;
`endif
        end
    end

endmodule

// File: tb/tb_arcade_round_controller.sv
// Directed bench for arcade_round_controller: vector table plus multi-cycle corner sequences.
module tb_arcade_round_controller;

    logic       clk = 1'b0;
    logic       reset, start, guess_valid;
    logic [3:0] guess;
    logic [3:0] target;
    logic       target_valid, hit, miss, game_over;
    logic [3:0] score;
`ifdef ARCADE_LIVES_EN
    logic [1:0] lives_left;
`endif

    int n_cmp = 0;
    int n_err = 0;

    arcade_round_controller dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .guess        (guess),
        .guess_valid  (guess_valid),
        .target       (target),
        .target_valid (target_valid),
        .hit          (hit),
        .miss         (miss),
        .score        (score),
        .game_over    (game_over)
`ifdef ARCADE_LIVES_EN
        ,
        .lives_left   (lives_left)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       s;
        logic       gv;
        logic [3:0] g;
        logic [3:0] tgt;
        logic       tv;
        logic       h;
        logic       m;
        logic [3:0] sc;
        logic       go;
    } vec_t;

    vec_t vecs [0:10];

    function automatic logic [3:0] lfsr_next(input logic [3:0] l);
        return {l[2:0], l[3] ^ l[2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge
    task automatic cyc(input logic r, input logic s, input logic gv, input logic [3:0] g);
        reset       = r;
        start       = s;
        guess_valid = gv;
        guess       = g;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] tgt, input logic tv,
                             input logic h, input logic m, input logic [3:0] sc, input logic go);
        check({tag, ".target"}, 32'(target), 32'(tgt));
        check({tag, ".target_valid"}, 32'(target_valid), 32'(tv));
        check({tag, ".hit"}, 32'(hit), 32'(h));
        check({tag, ".miss"}, 32'(miss), 32'(m));
        check({tag, ".score"}, 32'(score), 32'(sc));
        check({tag, ".game_over"}, 32'(game_over), 32'(go));
    endtask

    initial begin
        logic [3:0] l;
        logic [3:0] last;

        reset = 1'b1; start = 1'b0; guess_valid = 1'b0; guess = '0;

        //           r     s     gv    g      tgt     tv    h     m     sc     go
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'd9, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd9,  1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'd9, 4'd9,  1'b0, 1'b1, 1'b0, 4'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd3,  1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd5, 4'd3,  1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd6,  1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd6,  1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd6, 4'd6,  1'b0, 1'b1, 1'b0, 4'd2, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd13, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0};

        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].r, vecs[i].s, vecs[i].gv, vecs[i].g);
            check_all($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].tv, vecs[i].h, vecs[i].m,
                      vecs[i].sc, vecs[i].go);
        end

        // Timeout: 15 silent cycles stay in WAIT, the 16th times out
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd0);
            check($sformatf("to_wait%0d.miss", i), 32'(miss), 32'd0);
            check($sformatf("to_wait%0d.tv", i), 32'(target_valid), 32'd1);
        end
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        check_all("timeout", 4'd13, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        check_all("after_to", 4'd10, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);

        // Guess on the final timer cycle is judged, not timed out
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd0);
        end
        check("last_wait.miss", 32'(miss), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd10);
        check_all("last_guess", 4'd10, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        check_all("last_next", 4'd5, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);

        // Full game of ten hits from a fresh reset
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        check_all("game_rst", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        l = 4'd9;
        last = 4'd0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd0);
            check($sformatf("g%0d.target", i), 32'(target), 32'(l));
            check($sformatf("g%0d.tv", i), 32'(target_valid), 32'd1);
            cyc(1'b0, 1'b0, 1'b1, l);
            check($sformatf("g%0d.hit", i), 32'(hit), 32'd1);
            check($sformatf("g%0d.score", i), 32'(score), 32'(i + 1));
            check($sformatf("g%0d.game_over", i), 32'(game_over), 32'(i == 9));
            last = l;
            l = lfsr_next(l);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, last);
            check_all($sformatf("done%0d", i), last, 1'b0, 1'b0, 1'b0, 4'd10, 1'b1);
        end
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        check_all("restart", last, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        check_all("restart_wait", l, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Reset mid-WAIT with start and guess_valid high
        cyc(1'b1, 1'b1, 1'b1, l);
        check_all("mid_rst", 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
`ifdef ARCADE_LIVES_EN
        check("mid_rst.lives", 32'(lives_left), 32'd3);
`endif
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        check_all("reseeded", 4'd9, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

`ifdef ARCADE_LIVES_EN
        l = 4'd9;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b1, ~l);
            check($sformatf("life%0d.miss", k), 32'(miss), 32'd1);
            check($sformatf("life%0d.lives", k), 32'(lives_left), 32'(2 - k));
            check($sformatf("life%0d.game_over", k), 32'(game_over), 32'(k == 2));
            l = lfsr_next(l);
            if (k < 2) begin
                cyc(1'b0, 1'b0, 1'b0, 4'd0);
                check($sformatf("life%0d.target", k), 32'(target), 32'(l));
            end
        end
`else
        // Without lives, repeated misses never end the game
        l = 4'd9;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b1, ~l);
            check($sformatf("nolife%0d.miss", k), 32'(miss), 32'd1);
            check($sformatf("nolife%0d.game_over", k), 32'(game_over), 32'd0);
            l = lfsr_next(l);
            cyc(1'b0, 1'b0, 1'b0, 4'd0);
            check($sformatf("nolife%0d.target", k), 32'(target), 32'(l));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
